ldst_mem_responder: RTL and testbench
=====================================

Name: ldst_mem_responder

Overview:
- Memory-side responder for the pipeline's load/store request port. It serves the `o_ldst_rd` / `o_ldst_wr` strobes that the execute-stage control raises.
- Accepts one word transaction at a time and stalls the requester through a wait-request handshake for a configurable number of wait states.
- Commits writes to, and returns reads from, an internal word-addressed data RAM.
- Sits between the datapath's load/store address/data registers and the data memory.

Parameters:
- ADDR_W, 8, log2 of RAM depth in 16-bit words (DEPTH = 2**ADDR_W).
- WAIT_CYCLES, 2, extra wait states per transaction (0..15).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_ldst_rd  in  1  read request, held until wait-request drops.
- i_ldst_wr  in  1  write request, held until wait-request drops.
- i_ldst_addr  in  16  byte address; bit 0 ignored; word index = addr[ADDR_W:1].
- i_ldst_wrdata  in  16  write data.
- o_ldst_rddata  out  16  read data, registered.
- o_ldst_waitrequest  out  1  high = requester must hold request and stall.
- o_ldst_err  out  1  sticky protocol/range error flag.

Behaviour:
- Reset (reset=0, async): state=IDLE, counter=0, o_ldst_rddata=16'h0000, o_ldst_err=0, latched op/addr/data cleared. RAM contents are not reset.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If rd|wr is high at a rising edge: latch op (wr has priority), word index and wrdata; load counter=WAIT_CYCLES; go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - counter>0: decrement.
  - counter==0: go to DONE. On this same edge a write commits to the RAM and a read loads o_ldst_rddata from the RAM at the latched index.
- DONE: one cycle only, then unconditionally go to IDLE.
- o_ldst_waitrequest is combinational: (i_ldst_rd | i_ldst_wr) & (state != DONE).
  - It is therefore low in DONE.
  - It is also low in IDLE while no request is present.
- Latency:
  - Request sampled at edge E0; completion visible during the cycle after edge E(WAIT_CYCLES+1).
  - The requester advances at edge E(WAIT_CYCLES+2).
  - With WAIT_CYCLES=0 the requester stalls for 2 cycles.
- Back-to-back: a request still asserted in the cycle after DONE (IDLE) starts a new transaction. There is at most one transaction per WAIT_CYCLES+3 cycles.
- rd and wr both high when sampled in IDLE: treated as a write; o_ldst_err set.
- Request dropped while BUSY: the latched transaction still completes; no stall is visible because waitrequest follows the request.
- Address/data changing while BUSY: ignored; the latched values are used.
- o_ldst_rddata holds its value until the next read completes; writes do not disturb it.
- Reset mid-transaction: the transaction is aborted. A write not yet past the BUSY->DONE edge is never committed.
- o_ldst_err clears only on reset.

Optional Feature:
- Macro: LDST_RANGE_CHK_EN.
- Defined:
  - A transaction with i_ldst_addr[15:ADDR_W+1] != 0 is out of range.
  - Out-of-range write: dropped; RAM unchanged.
  - Out-of-range read: returns 16'hDEAD.
  - Both cases set o_ldst_err.
  - Handshake timing is identical to an in-range access.
- Undefined: upper address bits are ignored; the index wraps modulo DEPTH; no range error is raised.

Decomposition:
- Package ldst_pkg:
  - state enum ldst_state_t {IDLE, BUSY, DONE};
  - WORD_W=16;
  - LDST_BAD_RDATA=16'hDEAD;
  - counter width CNT_W=4.
- Sub-module ldst_ram:
  - DEPTH x 16 array; synchronous write enable; combinational read at the latched index.
  - Instantiated once; the top holds the FSM, counter and handshake.

Test Plan:
- Reset, then idle with no request -> o_ldst_waitrequest=0, o_ldst_rddata=0, o_ldst_err=0.
- WAIT_CYCLES=2: write 16'hBEEF to addr 16'h0010, then read addr 16'h0010 -> waitrequest high exactly 4 cycles per access; rddata=16'hBEEF in the DONE cycle; stall count matches on both accesses.
- Write 16'h1234 to addr 0x0020; drop i_ldst_wr after 1 BUSY cycle and change addr to 0x0030 -> RAM[0x10]=16'h1234; RAM[0x18] unchanged.
- Assert reset mid-BUSY of a write of 16'hAAAA to addr 0x0040 -> state=IDLE, RAM[0x20] keeps its prior value, rddata=0.
- rd and wr asserted together with data 16'h5555 at addr 0x0002 -> write performed, o_ldst_err=1 and stays set until reset.
- LDST_RANGE_CHK_EN with ADDR_W=8:
  - read addr 16'h0400 -> rddata=16'hDEAD, err=1.
  - without the macro, write 16'h7777 to 16'h0402 -> readback at 16'h0002 returns 16'h7777.

Source files
------------

// File: rtl/ldst_pkg.sv
// Shared types and constants for the load/store memory responder.
//   ldst_state_t   : responder FSM state (IDLE -> BUSY -> DONE -> IDLE)
//   WORD_W         : data word width
//   CNT_W          : wait-state counter width
//   LDST_BAD_RDATA : read data returned for an out-of-range read
package ldst_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned CNT_W  = 4;

    localparam logic [WORD_W-1:0] LDST_BAD_RDATA = 16'hDEAD;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } ldst_state_t;

endpackage

// File: rtl/ldst_mem_responder_if.sv
// Load/store request port between the pipeline (master) and the memory
// responder (slave).
//   i_ldst_rd / i_ldst_wr   : read / write request, held while waitrequest is high
//   i_ldst_addr             : byte address (bit 0 ignored)
//   i_ldst_wrdata           : write data
//   o_ldst_rddata           : registered read data
//   o_ldst_waitrequest      : requester must hold its request and stall
//   o_ldst_err              : sticky protocol/range error
interface ldst_mem_responder_if;
    import ldst_pkg::*;

    logic              i_ldst_rd;
    logic              i_ldst_wr;
    logic [15:0]       i_ldst_addr;
    logic [WORD_W-1:0] i_ldst_wrdata;
    logic [WORD_W-1:0] o_ldst_rddata;
    logic              o_ldst_waitrequest;
    logic              o_ldst_err;

    modport master (
        output i_ldst_rd,
        output i_ldst_wr,
        output i_ldst_addr,
        output i_ldst_wrdata,
        input  o_ldst_rddata,
        input  o_ldst_waitrequest,
        input  o_ldst_err
    );

    modport slave (
        input  i_ldst_rd,
        input  i_ldst_wr,
        input  i_ldst_addr,
        input  i_ldst_wrdata,
        output o_ldst_rddata,
        output o_ldst_waitrequest,
        output o_ldst_err
    );

endinterface

// File: rtl/ldst_ram.sv
// Word-addressed data RAM for the load/store responder.
//   clk_i   : clock
//   we_i    : synchronous write enable
//   addr_i  : word index (shared by read and write)
//   wdata_i : write data
//   rdata_o : combinational read data at addr_i
// Contents are not reset.
module ldst_ram
    import ldst_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [WORD_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/ldst_mem_responder.sv
// Memory-side responder for the pipeline load/store port. Accepts one word
// transaction at a time, stalls the requester for WAIT_CYCLES wait states via
// waitrequest, then commits a write to / returns a read from the data RAM.
//   clk    : system clock, rising edge
//   reset  : asynchronous active-low reset
//   bus_io : load/store request port (slave side)
// Optional build macro LDST_RANGE_CHK_EN: addresses with any bit above the RAM
// index set are out of range; writes are dropped, reads return 16'hDEAD, and
// the sticky error flag is raised. Without it the index wraps modulo the depth.
module ldst_mem_responder
    import ldst_pkg::*;
#(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input logic                 clk,
    input logic                 reset,
    ldst_mem_responder_if.slave bus_io
);

    ldst_state_t       state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              op_wr_q;
    logic              oor_q;
    logic [ADDR_W-1:0] idx_q;
    logic [WORD_W-1:0] wdata_q;
    logic [WORD_W-1:0] rddata_q;
    logic              err_q;

    logic              req;
    logic              both_req;
    logic [15:0]       addr_hi;
    logic              addr_oor;
    logic              commit;
    logic              ram_we;
    logic [WORD_W-1:0] ram_rdata;
    logic              unused_addr_lsb;

    assign req      = bus_io.i_ldst_rd | bus_io.i_ldst_wr;
    assign both_req = bus_io.i_ldst_rd & bus_io.i_ldst_wr;
    assign addr_hi  = bus_io.i_ldst_addr >> (ADDR_W + 1);

    // Byte address bit 0 never selects anything in a word-addressed RAM.
    assign unused_addr_lsb = bus_io.i_ldst_addr[0];

`ifdef LDST_RANGE_CHK_EN
    assign addr_oor = |addr_hi;
`else
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr_hi;
    assign addr_oor       = 1'b0;
`endif

    // Last BUSY cycle: the write lands and read data is captured on this edge.
    assign commit = (state_q == BUSY) && (cnt_q == '0);
    assign ram_we = commit & op_wr_q & ~oor_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_wr_q  <= 1'b0;
            oor_q    <= 1'b0;
            idx_q    <= '0;
            wdata_q  <= '0;
            rddata_q <= '0;
            err_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req) begin
                        // Write wins when both strobes are raised together.
                        op_wr_q <= bus_io.i_ldst_wr;
                        oor_q   <= addr_oor;
                        idx_q   <= bus_io.i_ldst_addr[ADDR_W:1];
                        wdata_q <= bus_io.i_ldst_wrdata;
                        cnt_q   <= CNT_W'(WAIT_CYCLES);
                        state_q <= BUSY;
                        if (both_req || addr_oor) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        state_q <= DONE;
                        if (!op_wr_q) begin
                            rddata_q <= oor_q ? LDST_BAD_RDATA : ram_rdata;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    ldst_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .addr_i  (idx_q),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata)
    );

    // Follows the live request so a requester that drops out mid-BUSY sees no stall.
    assign bus_io.o_ldst_waitrequest = req & (state_q != DONE);
    assign bus_io.o_ldst_rddata      = rddata_q;
    assign bus_io.o_ldst_err         = err_q;

endmodule

// File: tb/tb_ldst_mem_responder.sv
// Scoreboard bench for ldst_mem_responder: the driver pushes the expected
// completion (read data, error flag, stall length) per transaction, and an
// independent monitor pops and compares whenever a held request sees
// waitrequest low.
module tb_ldst_mem_responder;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned WAIT   = 2;
    localparam int unsigned DEPTH  = 2 ** ADDR_W;

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        int          stalls;
    } exp_t;

    logic clk;
    logic reset;

    ldst_mem_responder_if bus ();

    ldst_mem_responder #(
        .ADDR_W      (ADDR_W),
        .WAIT_CYCLES (WAIT)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .bus_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    exp_t q[$];

    // Reference model state
    logic [15:0] m_mem [int];
    logic [15:0] m_rd;
    logic        m_err;
    int          written[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit is_oor(input logic [15:0] addr);
`ifdef LDST_RANGE_CHK_EN
        return (addr >> (ADDR_W + 1)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int idx_of(input logic [15:0] addr);
        return int'((addr >> 1) % DEPTH);
    endfunction

    // Apply one transaction to the model and return what the DUT must show.
    function automatic exp_t model_op(input bit rd, input bit wr, input logic [15:0] addr,
                                      input logic [15:0] data);
        exp_t e;
        int   idx;
        idx = idx_of(addr);
        if (rd && wr) m_err = 1'b1;
        if (is_oor(addr)) m_err = 1'b1;
        if (wr) begin
            if (!is_oor(addr)) begin
                m_mem[idx] = data;
                written.push_back(idx);
            end
        end else begin
            if (is_oor(addr))          m_rd = 16'hDEAD;
            else if (m_mem.exists(idx)) m_rd = m_mem[idx];
            else                       m_rd = 16'hxxxx;
        end
        e.rdata  = m_rd;
        e.err    = m_err;
        e.stalls = WAIT + 2;
        return e;
    endfunction

    task automatic drive_idle();
        bus.i_ldst_rd     = 1'b0;
        bus.i_ldst_wr     = 1'b0;
        bus.i_ldst_addr   = 16'h0;
        bus.i_ldst_wrdata = 16'h0;
    endtask

    // Full handshake: hold the request until waitrequest drops, then release.
    task automatic do_op(input bit rd, input bit wr, input logic [15:0] addr,
                         input logic [15:0] data);
        bit done;
        q.push_back(model_op(rd, wr, addr, data));
        @(posedge clk);
        #1;
        bus.i_ldst_rd     = rd;
        bus.i_ldst_wr     = wr;
        bus.i_ldst_addr   = addr;
        bus.i_ldst_wrdata = data;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (!bus.o_ldst_waitrequest) done = 1'b1;
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL handshake_timeout: addr %h still stalled after 40 cycles", addr);
        end
        @(posedge clk);
        #1;
        drive_idle();
    endtask

    // Monitor: count stall cycles of the current request and score completions.
    initial begin
        int   stall;
        exp_t e;
        stall = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                stall = 0;
            end else if (bus.i_ldst_rd || bus.i_ldst_wr) begin
                if (bus.o_ldst_waitrequest) begin
                    stall++;
                end else begin
                    if (q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_completion: no transaction outstanding");
                    end else begin
                        e = q.pop_front();
                        check("rddata", {16'h0, bus.o_ldst_rddata}, {16'h0, e.rdata});
                        check("err", {31'h0, bus.o_ldst_err}, {31'h0, e.err});
                        check("stall_cycles", stall, e.stalls);
                    end
                    stall = 0;
                end
            end else begin
                stall = 0;
            end
        end
    end

    initial begin
        logic [15:0] addr;
        logic [15:0] upper;
        int          idx;
        exp_t        dummy;

        m_rd  = 16'h0;
        m_err = 1'b0;
        drive_idle();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // Idle after reset
        @(negedge clk);
        check("rst_waitrequest", {31'h0, bus.o_ldst_waitrequest}, 32'h0);
        check("rst_rddata", {16'h0, bus.o_ldst_rddata}, 32'h0);
        check("rst_err", {31'h0, bus.o_ldst_err}, 32'h0);

        // Basic write then read
        do_op(1'b0, 1'b1, 16'h0010, 16'hBEEF);
        do_op(1'b1, 1'b0, 16'h0010, 16'h0000);

        // Request dropped after one BUSY cycle; address changes are ignored
        do_op(1'b0, 1'b1, 16'h0030, 16'h3030);
        dummy = model_op(1'b0, 1'b1, 16'h0020, 16'h1234);
        @(posedge clk);
        #1;
        bus.i_ldst_wr     = 1'b1;
        bus.i_ldst_addr   = 16'h0020;
        bus.i_ldst_wrdata = 16'h1234;
        @(posedge clk);
        @(posedge clk);
        #1;
        bus.i_ldst_wr     = 1'b0;
        bus.i_ldst_addr   = 16'h0030;
        bus.i_ldst_wrdata = 16'hFFFF;
        @(negedge clk);
        check("drop_no_stall", {31'h0, bus.o_ldst_waitrequest}, 32'h0);
        repeat (5) @(posedge clk);
        do_op(1'b1, 1'b0, 16'h0020, 16'h0000);
        do_op(1'b1, 1'b0, 16'h0030, 16'h0000);

        // Reset in the middle of a write's BUSY phase
        do_op(1'b0, 1'b1, 16'h0040, 16'h1111);
        do_op(1'b1, 1'b0, 16'h0040, 16'h0000);
        @(posedge clk);
        #1;
        bus.i_ldst_wr     = 1'b1;
        bus.i_ldst_addr   = 16'h0040;
        bus.i_ldst_wrdata = 16'hAAAA;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive_idle();
        m_rd  = 16'h0;
        m_err = 1'b0;
        #1;
        check("midrst_rddata", {16'h0, bus.o_ldst_rddata}, 32'h0);
        check("midrst_err", {31'h0, bus.o_ldst_err}, 32'h0);
        check("midrst_waitrequest", {31'h0, bus.o_ldst_waitrequest}, 32'h0);
        @(posedge clk);
        #1 reset = 1'b1;
        do_op(1'b1, 1'b0, 16'h0040, 16'h0000);

        // Both strobes together: acts as a write and raises the sticky error
        do_op(1'b1, 1'b1, 16'h0002, 16'h5555);
        do_op(1'b1, 1'b0, 16'h0002, 16'h0000);

`ifdef LDST_RANGE_CHK_EN
        do_op(1'b1, 1'b0, 16'h0400, 16'h0000);
        do_op(1'b0, 1'b1, 16'h0402, 16'h7777);
        do_op(1'b1, 1'b0, 16'h0002, 16'h0000);
`else
        // Upper address bits ignored: index wraps modulo the depth
        do_op(1'b0, 1'b1, 16'h0402, 16'h7777);
        do_op(1'b1, 1'b0, 16'h0002, 16'h0000);
`endif

        // Randomized traffic
        for (int i = 0; i < 60; i++) begin
            upper = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(1, 127)) : 16'h0;
            if (written.size() == 0 || $urandom_range(0, 1) == 0) begin
                idx  = int'($urandom_range(0, DEPTH - 1));
                addr = 16'((upper << (ADDR_W + 1)) | (idx << 1) | $urandom_range(0, 1));
                do_op($urandom_range(0, 15) == 0, 1'b1, addr, 16'($urandom));
            end else begin
                idx  = written[$urandom_range(0, written.size() - 1)];
                addr = 16'((upper << (ADDR_W + 1)) | (idx << 1) | $urandom_range(0, 1));
                do_op(1'b1, 1'b0, addr, 16'h0000);
            end
        end

        repeat (5) @(posedge clk);
        check("scoreboard_drained", q.size(), 0);
        check("final_err_sticky", {31'h0, bus.o_ldst_err}, {31'h0, m_err});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
